// File: rtl/status_link_tx_if.sv
// SPI link from the game master to the player slave.
// The master drives all three wires; the slave (or a bench model) observes them.
interface status_link_tx_if;
  logic oSCLK;
  logic oMOSI;
  logic oCS_n;

  modport master (
    output oSCLK,
    output oMOSI,
    output oCS_n
  );

  modport slave (
    input oSCLK,
    input oMOSI,
    input oCS_n
  );
endinterface

// File: rtl/status_link_tx.sv
// Mirrors the three game-status registers onto the player slave over SPI mode 0.
// Each register keeps a shadow of the value last sent. A register is only resent
// when its input differs from that shadow. After reset, one forced full sync runs.
// Every update is one 16-bit write frame {1'b1, 5'b0, idx, data}, sent MSB first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | CS_n high; pick the next pending register round-robin
// SETUP | CS_n low, MOSI = bit 15, SCLK low, for one half-period
// SHIFT | 32 SCLK half-periods; rise on odd ends, shift on even ends
// HOLD  | CS_n high inter-frame gap; shadow/force already updated
module status_link_tx #(
  parameter int CLK_DIV = 50,
  parameter int GAP_DIV = 2
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [7:0]              iCurrent_Status,
  input  logic [7:0]              iGame_Result,
  input  logic [7:0]              iChange_Status,
  status_link_tx_if.master        spi,
  output logic                    oBusy,
  output logic                    oDone,
  output logic [1:0]              oSent_Addr
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      shreg;
  logic [1:0]       lat_idx;
  logic [7:0]       lat_data;
  logic [7:0]       shadow [3];
  logic [2:0]       force_q;
  logic [1:0]       last_idx;

  logic [3:0]       pend;
  logic             sel_valid;
  logic [1:0]       sel_idx;
  logic [7:0]       sel_data;

  // (base + step) mod 3 for base in 0..2, step in 1..3
  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  // Pending flags: forced after reset, or live input differs from what the slave holds.
  // Bit 3 is a permanent zero so a 2-bit index never reads outside the vector.
  always_comb begin
    pend    = 4'b0000;
    pend[0] = force_q[0] | (iCurrent_Status != shadow[0]);
    pend[1] = force_q[1] | (iGame_Result    != shadow[1]);
    pend[2] = force_q[2] | (iChange_Status  != shadow[2]);
  end

  // Round-robin pick: scan last+1, last+2, last; the nearest pending register wins.
  always_comb begin
    logic [1:0] cand;
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int n = 3; n >= 1; n--) begin
      cand = wrap3(last_idx, 2'(n));
      if (pend[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Data for the selected register, captured into the frame when leaving IDLE.
  always_comb begin
    case (sel_idx)
      2'd0:    sel_data = iCurrent_Status;
      2'd1:    sel_data = iGame_Result;
      2'd2:    sel_data = iChange_Status;
      default: sel_data = 8'h00;
    endcase
  end

  // Frame sequencer: all SPI pins and status outputs are registered here.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      spi.oSCLK  <= 1'b0;
      spi.oMOSI  <= 1'b0;
      spi.oCS_n  <= 1'b1;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oSent_Addr <= 2'd0;
      div_cnt    <= '0;
      bit_cnt    <= 5'd0;
      gap_cnt    <= '0;
      shreg      <= 16'h0000;
      lat_idx    <= 2'd0;
      lat_data   <= 8'h00;
      force_q    <= 3'b111;
      last_idx   <= 2'd2;
      for (int k = 0; k < 3; k++) begin
        shadow[k] <= 8'h00;
      end
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            shreg     <= {1'b1, 5'b00000, sel_idx, sel_data};
            lat_idx   <= sel_idx;
            lat_data  <= sel_data;
            spi.oMOSI <= 1'b1;
            spi.oCS_n <= 1'b0;
            spi.oSCLK <= 1'b0;
            oBusy     <= 1'b1;
            div_cnt   <= DIV_LOAD;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            bit_cnt <= 5'd0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!bit_cnt[0]) begin
              // end of an odd half-period: slave samples MOSI on this rise
              spi.oSCLK <= 1'b1;
              bit_cnt   <= bit_cnt + 1'b1;
            end else if (bit_cnt != 5'd31) begin
              spi.oSCLK <= 1'b0;
              shreg     <= {shreg[14:0], 1'b0};
              spi.oMOSI <= shreg[14];
              bit_cnt   <= bit_cnt + 1'b1;
            end else begin
              // last fall coincides with CS_n release; commit the latched value
              spi.oSCLK  <= 1'b0;
              spi.oMOSI  <= 1'b0;
              spi.oCS_n  <= 1'b1;
              oDone      <= 1'b1;
              oSent_Addr <= lat_idx;
              last_idx   <= lat_idx;
              bit_cnt    <= 5'd0;
              gap_cnt    <= GAP_LOAD;
              state      <= HOLD;
              for (int k = 0; k < 3; k++) begin
                if (lat_idx == 2'(k)) begin
                  shadow[k]  <= lat_data;
                  force_q[k] <= 1'b0;
                end
              end
            end
          end
        end

        HOLD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
            div_cnt <= DIV_LOAD;
          end else begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
